time_keeper: RTL

Time-of-day source for the digital clock: divides the system clock to 1 Hz and maintains hour/min/sec in binary. Provides a two-key set mode for adjusting hours and minutes. Its hour/min/sec outputs feed the six-digit seven-segment scan driver directly; it is the producing end of that display interface.

---
 rtl/time_pkg.sv | 33 +++
 rtl/time_keeper_key_edge.sv | 25 ++
 rtl/time_keeper.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// +----------------------------------------------------------------------------+
// | time_pkg : shared mode encodings, field widths and limits for the          |
// |            time-of-day source and the display scan driver.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package time_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;

  // Increment with wrap to zero once the field limit is reached.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_keeper_key_edge.sv
// +----------------------------------------------------------------------------+
// | key_edge : registered key history with a one-cycle rising-edge pulse.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= key_i;
  end

  assign rise_o = key_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/time_keeper.sv
// +----------------------------------------------------------------------------+
// | time_keeper : 1 Hz prescaler, hh:mm:ss counters and two-key set mode.      |
// |               Optional digit blinking in set modes: TIME_KEEPER_BLINK_EN.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_mode,
  input  logic              key_up,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic [1:0]        mode,
  output logic              tick_1s,
  output logic [5:0]        blank
);

  localparam int unsigned    PW         = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_FREQ - 1);

  logic w_mode_edge, w_up_edge;

  key_edge u_mode_edge (.clk(clk), .rst(rst), .key_i(key_mode), .rise_o(w_mode_edge));
  key_edge u_up_edge   (.clk(clk), .rst(rst), .key_i(key_up),   .rise_o(w_up_edge));

  mode_e              state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [SEC_W-1:0]   sec_q, sec_d;

  logic       w_wrap, w_run, w_up_ok;
  logic [5:0] w_hour_inc, w_min_inc, w_sec_inc;

  assign w_wrap     = (presc_q == PRESC_LAST);
  assign w_run      = (state_q == MODE_RUN);
  // The mode key takes priority over a coincident up-key edge.
  assign w_up_ok    = w_up_edge & ~w_mode_edge & ~w_run;
  assign w_hour_inc = wrap_inc({1'b0, hour_q}, {1'b0, HOUR_MAX});
  assign w_min_inc  = wrap_inc(min_q, MIN_MAX);
  assign w_sec_inc  = wrap_inc(sec_q, SEC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MODE_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_mode_edge) begin
      case (state_q)
        MODE_RUN:      state_d = MODE_SET_HOUR;
        MODE_SET_HOUR: state_d = MODE_SET_MIN;
        default:       state_d = MODE_RUN;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (w_run) begin
      presc_d = w_wrap ? '0 : presc_q + 1'b1;
      if (w_wrap) begin
        sec_d = w_sec_inc;
        if (sec_q == SEC_MAX) begin
          min_d = w_min_inc;
          if (min_q == MIN_MAX) hour_d = w_hour_inc[HOUR_W-1:0];
        end
      end
    end else begin
`ifdef TIME_KEEPER_BLINK_EN
      presc_d = w_wrap ? '0 : presc_q + 1'b1;
`else
      presc_d = '0;
`endif
      if (w_up_ok) begin
        if (state_q == MODE_SET_HOUR) hour_d = w_hour_inc[HOUR_W-1:0];
        else                          min_d  = w_min_inc;
      end
    end
    // Restart the second so the first tick lands a full period after exit.
    if (w_mode_edge && state_q == MODE_SET_MIN) begin
      presc_d = '0;
      sec_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

`ifdef TIME_KEEPER_BLINK_EN
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2 - 1);

  logic toggle_q, toggle_d;

  always_comb begin
    toggle_d = toggle_q;
    if (w_up_ok)                                   toggle_d = 1'b0;
    else if (presc_q == PRESC_HALF || w_wrap)      toggle_d = ~toggle_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_q <= 1'b0;
    else     toggle_q <= toggle_d;
  end
`endif

  always_comb begin
    mode    = state_q;
    tick_1s = w_run & w_wrap;
    hour    = hour_q;
    min     = min_q;
    sec     = sec_q;
    blank   = 6'b0;
`ifdef TIME_KEEPER_BLINK_EN
    if (state_q == MODE_SET_HOUR)     blank = {toggle_q, toggle_q, 4'b0};
    else if (state_q == MODE_SET_MIN) blank = {2'b0, toggle_q, toggle_q, 2'b0};
`endif
  end

endmodule

`default_nettype wire
